// File: rtl/div_sched.sv
// Round-robin scheduler sharing one unsigned 32-step restoring divider between NREQ requesters.
// Applies RISC-V DIV/DIVU/REM/REMU sign rules and short-cuts divide-by-zero and signed overflow.
module div_sched #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    op,
  input  logic [32*NREQ-1:0]   a,
  input  logic [32*NREQ-1:0]   b,
  output logic [NREQ-1:0]      ack,
  output logic                 busy,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_data
);

  localparam int unsigned W   = 32;
  localparam int unsigned CNW = 6;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_KICK = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [W-1:0]   data_q, data_d;
  logic           is_rem_q, is_rem_d;
  logic           neg_q_q, neg_q_d;
  logic           neg_r_q, neg_r_d;
  logic [W-1:0]   mag_a_q, mag_a_d;
  logic [W-1:0]   mag_b_q, mag_b_d;

  // Shared divider core: kick/ready handshake, synchronous active-high reset.
  logic           core_srst;
  logic           core_kick;
  logic           core_ready;
  logic           core_busy_q, core_busy_d;
  logic [CNW-1:0] core_cnt_q, core_cnt_d;
  logic [W-1:0]   core_quo_q, core_quo_d;
  logic [W-1:0]   core_rem_q, core_rem_d;
  logic [W-1:0]   core_div_q, core_div_d;
  logic [W:0]     core_shift;
  logic [W:0]     core_diff;

  logic [1:0]     op_arr [NREQ];
  logic [W-1:0]   a_arr  [NREQ];
  logic [W-1:0]   b_arr  [NREQ];

  logic           found_c;
  logic [IDW-1:0] gnt_c;
  logic [NREQ-1:0] ack_c;

  logic [1:0]     op_g;
  logic [W-1:0]   a_g;
  logic [W-1:0]   b_g;
  logic           sgn;

  assign core_srst  = ~reset;
  assign core_kick  = (state_q == S_KICK);
  assign core_ready = ~core_busy_q;

  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) begin
      op_arr[i] = op[2*i +: 2];
      a_arr[i]  = a[W*i +: W];
      b_arr[i]  = b[W*i +: W];
    end
  end

  // Round-robin search starting just after the last grant.
  always_comb begin
    int unsigned idx;
    found_c = 1'b0;
    gnt_c   = '0;
    idx     = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = (32'(ptr_q) + i) % NREQ;
      if (!found_c && req[IDW'(idx)]) begin
        found_c = 1'b1;
        gnt_c   = IDW'(idx);
      end
    end
  end

  always_comb begin
    core_busy_d = core_busy_q;
    core_cnt_d  = core_cnt_q;
    core_quo_d  = core_quo_q;
    core_rem_d  = core_rem_q;
    core_div_d  = core_div_q;
    core_shift  = {core_rem_q, core_quo_q[W-1]};
    core_diff   = core_shift - {1'b0, core_div_q};
    if (core_kick && !core_busy_q) begin
      core_busy_d = 1'b1;
      core_cnt_d  = CNW'(W);
      core_quo_d  = mag_a_q;
      core_rem_d  = '0;
      core_div_d  = mag_b_q;
    end else if (core_busy_q) begin
      // One restoring step per cycle; borrow out means the trial subtract failed.
      if (!core_diff[W]) begin
        core_rem_d = core_diff[W-1:0];
        core_quo_d = {core_quo_q[W-2:0], 1'b1};
      end else begin
        core_rem_d = core_shift[W-1:0];
        core_quo_d = {core_quo_q[W-2:0], 1'b0};
      end
      core_cnt_d = core_cnt_q - CNW'(1);
      if (core_cnt_q == CNW'(1)) core_busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (core_srst) begin
      core_busy_q <= 1'b0;
      core_cnt_q  <= '0;
      core_quo_q  <= '0;
      core_rem_q  <= '0;
      core_div_q  <= '0;
    end else begin
      core_busy_q <= core_busy_d;
      core_cnt_q  <= core_cnt_d;
      core_quo_q  <= core_quo_d;
      core_rem_q  <= core_rem_d;
      core_div_q  <= core_div_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    data_d   = data_q;
    is_rem_d = is_rem_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    ack_c    = '0;
    op_g     = op_arr[gnt_c];
    a_g      = a_arr[gnt_c];
    b_g      = b_arr[gnt_c];
    sgn      = ~op_g[0];
    case (state_q)
      S_IDLE: begin
        if (found_c && reset) begin
          ack_c[gnt_c] = 1'b1;
          ptr_d        = gnt_c;
          id_d         = gnt_c;
          is_rem_d     = op_g[1];
          if (b_g == '0) begin
            data_d  = op_g[1] ? a_g : '1;
            state_d = S_RESP;
          end else if (sgn && a_g == 32'h8000_0000 && b_g == 32'hFFFF_FFFF) begin
            data_d  = op_g[1] ? '0 : 32'h8000_0000;
            state_d = S_RESP;
          end else begin
            neg_q_d = sgn & (a_g[W-1] ^ b_g[W-1]);
            neg_r_d = sgn & a_g[W-1];
            mag_a_d = (sgn && a_g[W-1]) ? -a_g : a_g;
            mag_b_d = (sgn && b_g[W-1]) ? -b_g : b_g;
            state_d = S_KICK;
          end
        end
      end
      S_KICK: state_d = S_WAIT;
      S_WAIT: begin
        if (core_ready) begin
          if (is_rem_q) data_d = neg_r_q ? -core_rem_q : core_rem_q;
          else          data_d = neg_q_q ? -core_quo_q : core_quo_q;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= IDW'(NREQ - 1);
      id_q     <= '0;
      data_q   <= '0;
      is_rem_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      data_q   <= data_d;
      is_rem_q <= is_rem_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
    end
  end

  assign ack       = ack_c;
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;

endmodule

// File: tb/tb_div_sched.sv
// Bench for div_sched: vector table with latency checks, scoreboard on every response,
// plus arbitration, backpressure and mid-operation reset sequences.
module tb_div_sched;
  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic                 clk;
  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [2*NREQ-1:0]    op;
  logic [32*NREQ-1:0]   a;
  logic [32*NREQ-1:0]   b;
  logic [NREQ-1:0]      ack;
  logic                 busy;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [31:0]          rsp_data;

  typedef struct {
    int          id;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [IDW-1:0] id;
    logic [31:0]    data;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   ack_log[$];
  int   n_rsp;
  int   kick_cnt;
  int   n_chk;
  int   n_pass;
  vec_t vecs[14];

  div_sched #(.NREQ(NREQ)) dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .a(a), .b(b),
    .ack(ack), .busy(busy), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [31:0] sx;
    logic signed [31:0] sy;
    sx = x;
    sy = y;
    if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
    case (o)
      2'd0:    return 32'(sx / sy);
      2'd1:    return x / y;
      2'd2:    return 32'(sx % sy);
      default: return x % y;
    endcase
  endfunction

  // Scoreboard: push on accept, pop on response handshake.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      sbq.delete();
    end else begin
      if (dut.core_kick) kick_cnt++;
      if (rsp_valid && rsp_ready) begin
        if (sbq.size() == 0) begin
          check("sb_unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          check("sb_rsp_id", 32'(rsp_id), 32'(e.id));
          check("sb_rsp_data", rsp_data, e.data);
        end
        n_rsp++;
      end
      if (ack != '0) begin
        check("ack_onehot", 32'($countones(ack)), 32'd1);
        check("ack_only_idle", 32'(busy), 32'd0);
        for (int i = 0; i < NREQ; i++) begin
          if (ack[i]) begin
            sbq.push_back('{IDW'(i), model(op[2*i +: 2], a[32*i +: 32], b[32*i +: 32])});
            ack_log.push_back(i);
          end
        end
      end
    end
  end

  task automatic do_op(input int id, input logic [1:0] o, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] ev, input int el);
    int n;
    int k0;
    @(negedge clk);
    op[2*id +: 2] = o;
    a[32*id +: 32] = av;
    b[32*id +: 32] = bv;
    req[id] = 1'b1;
    rsp_ready = 1'b0;
    #1;
    n = 0;
    while (!ack[id] && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (!ack[id]) begin
      check("ack_timeout", 32'd0, 32'd1);
      req[id] = 1'b0;
      return;
    end
    k0 = kick_cnt;
    @(negedge clk);
    req[id] = 1'b0;
    n = 1;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'(el));
    check("rsp_data", rsp_data, ev);
    check("rsp_id", 32'(rsp_id), 32'(id));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    check("kick_count", 32'(kick_cnt - k0), (el == 1) ? 32'd0 : 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ack_log.delete();
  endtask

  task automatic wait_rsp(input int limit);
    int n;
    n = 0;
    while (!rsp_valid && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("rsp_wait_timeout", 32'(rsp_valid), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish at %0t", $time);
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    n_chk = 0; n_pass = 0; n_rsp = 0; kick_cnt = 0;
    reset = 1'b0; req = '0; op = '0; a = '0; b = '0; rsp_ready = 1'b0;

    vecs[0]  = '{0, 2'd0, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 35};
    vecs[1]  = '{0, 2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 35};
    vecs[2]  = '{0, 2'd1, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 35};
    vecs[3]  = '{0, 2'd3, 32'hFFFF_FFF9, 32'd2,         32'd1,         35};
    vecs[4]  = '{0, 2'd0, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[5]  = '{0, 2'd3, 32'd5,         32'd0,         32'd5,         1};
    vecs[6]  = '{0, 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[7]  = '{0, 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
    vecs[8]  = '{1, 2'd0, 32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, 35};
    vecs[9]  = '{1, 2'd2, 32'd20,        32'hFFFF_FFFD, 32'd2,         35};
    vecs[10] = '{1, 2'd0, 32'h8000_0000, 32'd1,         32'h8000_0000, 35};
    vecs[11] = '{0, 2'd2, 32'h8000_0000, 32'd3,         32'hFFFF_FFFE, 35};
    vecs[12] = '{1, 2'd1, 32'h8000_0000, 32'd0,         32'hFFFF_FFFF, 1};
    vecs[13] = '{0, 2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         35};

    repeat (2) @(negedge clk);
    #1;
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    check("reset_rsp_data", rsp_data, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 14; i++)
      do_op(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Backpressure: response held, pending request only acked after the handshake.
    @(negedge clk);
    op[1:0] = 2'd1; a[31:0] = 32'd77; b[31:0] = 32'd5; req[0] = 1'b1; rsp_ready = 1'b0;
    #1;
    n = 0;
    while (!ack[0] && n < 200) begin @(negedge clk); #1; n++; end
    check("bp_ack0", 32'(ack[0]), 32'd1);
    @(negedge clk);
    req[0] = 1'b0;
    op[3:2] = 2'd0; a[63:32] = 32'hFFFF_FFF7; b[63:32] = 32'd4; req[1] = 1'b1;
    n = 0;
    while (!rsp_valid && n < 200) begin
      #1;
      check("bp_busy_noack", 32'(ack), 32'd0);
      @(negedge clk);
      n++;
    end
    check("bp_data", rsp_data, 32'd15);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check("bp_hold_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold_data", rsp_data, 32'd15);
      check("bp_hold_id", 32'(rsp_id), 32'd0);
      check("bp_hold_noack", 32'(ack), 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_handshake_noack", 32'(ack), 32'd0);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    check("bp_valid_drop", 32'(rsp_valid), 32'd0);
    check("bp_next_ack", 32'(ack), 32'd2);
    @(negedge clk);
    req[1] = 1'b0;
    wait_rsp(200);
    check("bp_data1", rsp_data, 32'hFFFF_FFFE);
    check("bp_id1", 32'(rsp_id), 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset during WAIT: outputs cleared, aborted request never answered.
    @(negedge clk);
    op[1:0] = 2'd1; a[31:0] = 32'd1000; b[31:0] = 32'd3; req[0] = 1'b1;
    #1;
    n = 0;
    while (!ack[0] && n < 200) begin @(negedge clk); #1; n++; end
    check("rst_ack0", 32'(ack[0]), 32'd1);
    @(negedge clk);
    req[0] = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    req[1] = 1'b1; op[3:2] = 2'd1; a[63:32] = 32'd5; b[63:32] = 32'd1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_id", 32'(rsp_id), 32'd0);
      check("rst_rsp_data", rsp_data, 32'd0);
      @(negedge clk); #1;
    end
    req[1] = 1'b0;
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid) n++;
    end
    check("rst_no_stale_rsp", 32'(n), 32'd0);
    do_op(0, 2'd1, 32'd100, 32'd7, 32'd14, 35);

    // Arbitration: both requesters held high, strict alternation from requester 0.
    do_reset();
    @(negedge clk);
    n_rsp = 0;
    op[1:0] = 2'd1; a[31:0] = 32'd1000; b[31:0] = 32'd3;
    op[3:2] = 2'd3; a[63:32] = 32'd1000; b[63:32] = 32'd7;
    rsp_ready = 1'b1;
    req = 2'b11;
    n = 0;
    while (n_rsp < 4 && n < 400) begin @(negedge clk); n++; end
    req = 2'b00;
    n = 0;
    while ((busy || sbq.size() != 0) && n < 100) begin @(negedge clk); n++; end
    rsp_ready = 1'b0;
    check("arb_rsp_count", (n_rsp >= 4) ? 32'd1 : 32'd0, 32'd1);
    check("arb_drained", 32'(sbq.size()), 32'd0);
    for (int i = 0; i < 4; i++)
      check("arb_order", (i < ack_log.size()) ? 32'(ack_log[i]) : 32'hFFFF_FFFF, 32'(i % 2));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
